// File: rtl/hwpe_stream_sink_strided.sv
// Multi-port TCDM store engine: drains one HWPE stream into NB_TCDM_PORTS 32-bit
// write ports, with addresses from a 2-D (word stride / line stride) generator.
module hwpe_stream_sink_strided #(
  parameter int unsigned NB_TCDM_PORTS = 4,
  parameter int unsigned LEN_WIDTH     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [31:0]                  base_addr_i,
  input  logic [31:0]                  word_stride_i,
  input  logic [31:0]                  line_stride_i,
  input  logic [LEN_WIDTH-1:0]         line_len_i,
  input  logic [LEN_WIDTH-1:0]         tot_len_i,
  input  logic                         stream_valid_i,
  output logic                         stream_ready_o,
  input  logic [32*NB_TCDM_PORTS-1:0]  stream_data_i,
  input  logic [4*NB_TCDM_PORTS-1:0]   stream_strb_i,
  output logic [NB_TCDM_PORTS-1:0]     tcdm_req_o,
  input  logic [NB_TCDM_PORTS-1:0]     tcdm_gnt_i,
  output logic [32*NB_TCDM_PORTS-1:0]  tcdm_add_o,
  output logic [NB_TCDM_PORTS-1:0]     tcdm_wen_o,
  output logic [4*NB_TCDM_PORTS-1:0]   tcdm_be_o,
  output logic [32*NB_TCDM_PORTS-1:0]  tcdm_data_o,
  output logic                         ready_start_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [LEN_WIDTH-1:0]         beat_cnt_o
);

  localparam int unsigned N = NB_TCDM_PORTS;

  typedef enum logic [1:0] {IDLE, WORKING, DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          cur_addr_q, line_base_q, word_stride_q, line_stride_q;
  logic [LEN_WIDTH-1:0] line_len_q, tot_len_q, beat_cnt_q, line_cnt_q;
  logic [N-1:0]         granted_q;
  logic [N-1:0]         need;
  logic                 working, accept;
  logic [LEN_WIDTH-1:0] beat_cnt_nxt;
  logic [31:0]          word_addr, next_line_base;

  assign working        = (state_q == WORKING);
  assign word_addr      = {cur_addr_q[31:2], 2'b00};
  assign beat_cnt_nxt   = beat_cnt_q + 1'b1;
  assign next_line_base = line_base_q + line_stride_q;

  for (genvar ii = 0; ii < N; ii++) begin : g_need
    assign need[ii] = stream_valid_i & (|stream_strb_i[4*ii +: 4]);
  end

  // The beat may leave only once every port that needs it is either already
  // granted or being granted right now.
  assign stream_ready_o = working & ((need & ~(granted_q | (tcdm_req_o & tcdm_gnt_i))) == '0);
  assign accept         = stream_valid_i & stream_ready_o;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    tcdm_req_o  = '0;
    tcdm_add_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    if (working) begin
      for (int ii = 0; ii < int'(N); ii++) begin
        tcdm_req_o[ii]          = need[ii] & ~granted_q[ii];
        tcdm_add_o[32*ii +: 32] = word_addr + 32'(4 * ii);
        tcdm_be_o[4*ii +: 4]    = stream_strb_i[4*ii +: 4];
        tcdm_data_o[32*ii +: 32] = stream_data_i[32*ii +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (tot_len_i == '0) ? DONE : WORKING;
      WORKING: if (accept && (beat_cnt_nxt == tot_len_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments only; the small config
    // registers are reset along with the counters so outputs are clean after clear.
    if (rst_i || clear_i) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      line_base_q   <= '0;
      word_stride_q <= '0;
      line_stride_q <= '0;
      line_len_q    <= '0;
      tot_len_q     <= '0;
      beat_cnt_q    <= '0;
      line_cnt_q    <= '0;
      granted_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        cur_addr_q    <= base_addr_i;
        line_base_q   <= base_addr_i;
        word_stride_q <= word_stride_i;
        line_stride_q <= line_stride_i;
        line_len_q    <= line_len_i;
        tot_len_q     <= tot_len_i;
        beat_cnt_q    <= '0;
        line_cnt_q    <= '0;
        granted_q     <= '0;
      end else if (working) begin
        if (accept) begin
          granted_q  <= '0;
          beat_cnt_q <= beat_cnt_nxt;
          if (line_len_q != '0 && line_cnt_q == line_len_q - 1'b1) begin
            line_base_q <= next_line_base;
            cur_addr_q  <= next_line_base;
            line_cnt_q  <= '0;
          end else begin
            cur_addr_q <= cur_addr_q + word_stride_q;
            line_cnt_q <= line_cnt_q + 1'b1;
          end
        end else begin
          granted_q <= granted_q | (tcdm_req_o & tcdm_gnt_i);
        end
      end
    end
  end

  assign tcdm_wen_o    = '0;
  assign ready_start_o = (state_q == IDLE);
  assign busy_o        = (state_q == WORKING) || (state_q == DONE);
  assign done_o        = (state_q == DONE);
  assign beat_cnt_o    = beat_cnt_q;

endmodule

// File: tb/tb_hwpe_stream_sink_strided.sv
// Directed bench for hwpe_stream_sink_strided: strided/line addressing, partial
// grants, zero-strobe beats, zero-length jobs, ignored restarts and soft clear.
module tb_hwpe_stream_sink_strided;

  localparam int N  = 4;
  localparam int LW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i, clear_i, start_i;
  logic [31:0]     base_addr_i, word_stride_i, line_stride_i;
  logic [LW-1:0]   line_len_i, tot_len_i;
  logic            stream_valid_i, stream_ready_o;
  logic [32*N-1:0] stream_data_i;
  logic [4*N-1:0]  stream_strb_i;
  logic [N-1:0]    tcdm_req_o, tcdm_gnt_i, tcdm_wen_o;
  logic [32*N-1:0] tcdm_add_o, tcdm_data_o;
  logic [4*N-1:0]  tcdm_be_o;
  logic            ready_start_o, busy_o, done_o;
  logic [LW-1:0]   beat_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  hwpe_stream_sink_strided #(.NB_TCDM_PORTS(N), .LEN_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .word_stride_i(word_stride_i),
    .line_stride_i(line_stride_i), .line_len_i(line_len_i), .tot_len_i(tot_len_i),
    .stream_valid_i(stream_valid_i), .stream_ready_o(stream_ready_o),
    .stream_data_i(stream_data_i), .stream_strb_i(stream_strb_i),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .ready_start_o(ready_start_o), .busy_o(busy_o), .done_o(done_o),
    .beat_cnt_o(beat_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] ws,
                          input logic [31:0] ls, input logic [LW-1:0] ll,
                          input logic [LW-1:0] tot);
    base_addr_i = base; word_stride_i = ws; line_stride_i = ls;
    line_len_i = ll; tot_len_i = tot; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    logic [31:0] t2_addr [5];
    t2_addr = '{32'h000, 32'h010, 32'h400, 32'h410, 32'h800};

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
    base_addr_i = '0; word_stride_i = '0; line_stride_i = '0;
    line_len_i = '0; tot_len_i = '0;
    stream_valid_i = 1'b0; stream_data_i = '0; stream_strb_i = '0; tcdm_gnt_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    settle();
    check("rst ready_start", 64'(ready_start_o), 64'd1);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst done", 64'(done_o), 64'd0);
    check("rst req", 64'(tcdm_req_o), 64'd0);
    check("rst beat_cnt", 64'(beat_cnt_o), 64'd0);
    check("rst wen", 64'(tcdm_wen_o), 64'd0);

    // T1: linear addressing, all grants immediate, one beat per cycle.
    do_start(32'h100, 32'd16, 32'd0, '0, 16'd3);
    tcdm_gnt_i = '1; stream_valid_i = 1'b1; stream_strb_i = '1;
    for (int k = 0; k < 3; k++) begin
      stream_data_i = {32'hD3D3_0000 + 32'(k), 32'hD2D2_0000 + 32'(k),
                       32'hD1D1_0000 + 32'(k), 32'hD0D0_0000 + 32'(k)};
      settle();
      check($sformatf("t1 req b%0d", k), 64'(tcdm_req_o), 64'hF);
      check($sformatf("t1 ready b%0d", k), 64'(stream_ready_o), 64'd1);
      check($sformatf("t1 add0 b%0d", k), 64'(tcdm_add_o[31:0]), 64'(32'h100 + 32'(16*k)));
      check($sformatf("t1 add3 b%0d", k), 64'(tcdm_add_o[127:96]), 64'(32'h10C + 32'(16*k)));
      check($sformatf("t1 data2 b%0d", k), 64'(tcdm_data_o[95:64]), 64'(32'hD2D2_0000 + 32'(k)));
      tick();
    end
    stream_valid_i = 1'b0;
    settle();
    check("t1 done", 64'(done_o), 64'd1);
    check("t1 busy in done", 64'(busy_o), 64'd1);
    check("t1 beat_cnt", 64'(beat_cnt_o), 64'd3);
    tick();
    check("t1 done drops", 64'(done_o), 64'd0);
    check("t1 back idle", 64'(ready_start_o), 64'd1);

    // T2: 2-beat lines with a 0x400 line stride.
    do_start(32'h0, 32'd16, 32'h400, 16'd2, 16'd5);
    stream_valid_i = 1'b1; stream_strb_i = '1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("t2 add b%0d", k), 64'(tcdm_add_o[31:0]), 64'(t2_addr[k]));
      tick();
    end
    stream_valid_i = 1'b0;
    settle();
    check("t2 done", 64'(done_o), 64'd1);
    tick();

    // T3: port 2 waits three cycles for its grant; the others are granted at once.
    do_start(32'h200, 32'd4, 32'd0, '0, 16'd1);
    stream_valid_i = 1'b1; stream_strb_i = '1;
    stream_data_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    tcdm_gnt_i = 4'b1011;
    settle();
    check("t3 c1 req", 64'(tcdm_req_o), 64'hF);
    check("t3 c1 ready", 64'(stream_ready_o), 64'd0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (c == 4) tcdm_gnt_i = 4'b1111;
      settle();
      check($sformatf("t3 c%0d req", c), 64'(tcdm_req_o), 64'b0100);
      check($sformatf("t3 c%0d add2", c), 64'(tcdm_add_o[95:64]), 64'h208);
      check($sformatf("t3 c%0d data2", c), 64'(tcdm_data_o[95:64]), 64'h2222_2222);
      check($sformatf("t3 c%0d ready", c), 64'(stream_ready_o), (c == 4) ? 64'd1 : 64'd0);
    end
    tick();
    stream_valid_i = 1'b0;
    settle();
    check("t3 done", 64'(done_o), 64'd1);
    tick();

    // T4: partial strobes, then a zero-strobe beat that is skipped but counted.
    do_start(32'h1000, 32'd8, 32'd0, '0, 16'd4);
    stream_valid_i = 1'b1; tcdm_gnt_i = '1;
    stream_strb_i = 16'h0F31;
    settle();
    check("t4 b0 req", 64'(tcdm_req_o), 64'b0111);
    check("t4 b0 be", 64'(tcdm_be_o), 64'h0F31);
    tick();
    stream_strb_i = '1;
    tick();
    stream_strb_i = '0;
    settle();
    check("t4 b2 req", 64'(tcdm_req_o), 64'd0);
    check("t4 b2 ready", 64'(stream_ready_o), 64'd1);
    tick();
    stream_strb_i = '1;
    settle();
    check("t4 b3 add0", 64'(tcdm_add_o[31:0]), 64'h1018);
    tick();
    stream_valid_i = 1'b0;
    settle();
    check("t4 done", 64'(done_o), 64'd1);
    check("t4 beat_cnt", 64'(beat_cnt_o), 64'd4);
    tick();

    // T5: zero-length job, then a restart attempt during WORKING.
    do_start(32'h40, 32'd4, 32'd0, '0, 16'd0);
    settle();
    check("t5 zero done", 64'(done_o), 64'd1);
    check("t5 zero req", 64'(tcdm_req_o), 64'd0);
    tick();
    check("t5 zero idle", 64'(ready_start_o), 64'd1);
    do_start(32'h0, 32'd4, 32'd0, '0, 16'd2);
    do_start(32'h5000, 32'd64, 32'd0, '0, 16'd0);
    settle();
    check("t5 restart busy", 64'(busy_o), 64'd1);
    check("t5 restart done", 64'(done_o), 64'd0);
    stream_valid_i = 1'b1; stream_strb_i = '1;
    settle();
    check("t5 b0 add", 64'(tcdm_add_o[31:0]), 64'h0);
    tick();
    check("t5 b1 add", 64'(tcdm_add_o[31:0]), 64'h4);
    tick();
    stream_valid_i = 1'b0;
    settle();
    check("t5 done", 64'(done_o), 64'd1);
    tick();

    // T6: soft clear while port 1 is still waiting for its grant.
    do_start(32'h300, 32'd16, 32'd0, '0, 16'd3);
    stream_valid_i = 1'b1; stream_strb_i = '1; tcdm_gnt_i = 4'b1101;
    tick();
    settle();
    check("t6 pending req", 64'(tcdm_req_o), 64'b0010);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    settle();
    check("t6 idle", 64'(ready_start_o), 64'd1);
    check("t6 req", 64'(tcdm_req_o), 64'd0);
    check("t6 beat_cnt", 64'(beat_cnt_o), 64'd0);
    check("t6 done", 64'(done_o), 64'd0);
    check("t6 ready", 64'(stream_ready_o), 64'd0);
    tick();
    check("t6 no late done", 64'(done_o), 64'd0);
    stream_valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
